// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the score award sequencer.
//   state_e          : sequencer FSM states (IDLE, PULSE, SETTLE)
//   NUM_DIGITS_DEF   : default number of digits in the score chain
//   AMOUNT_WIDTH_DEF : default width of an award amount (in pulses)
//   settle_len()     : cycles to wait after a pulse so a carry can ripple
//                      through every digit of the chain
// -----------------------------------------------------------------------------
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    localparam int NUM_DIGITS_DEF   = 4;
    localparam int AMOUNT_WIDTH_DEF = 4;

    // A carry launched by a pulse on digit 0 needs one cycle per further
    // digit to reach the top, so the gap after a pulse is NUM_DIGITS-1.
    function automatic int settle_len(input int num_digits);
        return (num_digits > 1) ? num_digits - 1 : 0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin winner selection. The search starts at ptr+1 and
// wraps, so the most recently served requester has lowest priority.
//   req   [N-1:0]  : request vector
//   ptr   [PW-1:0] : index of the last winner (register lives in the parent)
//   grant [N-1:0]  : one-hot winner, all zero when req is zero
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_award_sequencer.sv
// -----------------------------------------------------------------------------
// score_award_sequencer
// Arbitrates score-award requests and converts each granted award into a
// paced train of one-cycle count pulses into the decimal digit chain. Pulses
// are spaced NUM_DIGITS cycles apart so a digit never receives a pulse while
// a carry into it is still in flight.
//   clk, resetN  : clock, asynchronous active-low reset
//   req          : per-source award request, held until granted
//   req_amount   : per-source number of pulses (packed, AMOUNT_WIDTH each)
//   req_digit    : per-source target digit (packed, DIGIT_SEL_WIDTH each)
//   freeze       : blocks new grants (only looked at in IDLE)
//   top_carry    : carry out of the most significant digit
//   grant        : one-hot, one-cycle acknowledge of the winning source
//   count_pulse  : one-hot, one-cycle increment of the selected digit
//   busy         : award window active (grant cycle through return to IDLE)
//   overflow     : sticky, score wrapped past its maximum
// All outputs are registered.
// -----------------------------------------------------------------------------
module score_award_sequencer
    import score_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int AMOUNT_WIDTH    = AMOUNT_WIDTH_DEF,
    parameter int NUM_DIGITS      = NUM_DIGITS_DEF,
    parameter int DIGIT_SEL_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               resetN,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*AMOUNT_WIDTH-1:0]    req_amount,
    input  logic [NUM_REQ*DIGIT_SEL_WIDTH-1:0] req_digit,
    input  logic                               freeze,
    input  logic                               top_carry,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [NUM_DIGITS-1:0]              count_pulse,
    output logic                               busy,
    output logic                               overflow
);

    localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SETTLE_LEN = settle_len(NUM_DIGITS);
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    state_e                       state_q, state_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [AMOUNT_WIDTH-1:0]      remaining_q, remaining_d;
    logic [DIGIT_SEL_WIDTH-1:0]   digit_q, digit_d;
    logic [CNT_W-1:0]             settle_q, settle_d;
    logic [NUM_REQ-1:0]           grant_q, grant_d;
    logic [NUM_DIGITS-1:0]        pulse_q, pulse_d;
    logic                         busy_q, busy_d;
    logic                         overflow_q, overflow_d;

    logic [NUM_REQ-1:0]           win;
    logic [PTR_W-1:0]             win_idx;
    logic [AMOUNT_WIDTH-1:0]      win_amount;
    logic [DIGIT_SEL_WIDTH-1:0]   win_digit;
    logic                         win_digit_ok;
    logic [NUM_DIGITS-1:0]        digit_onehot;

    rr_arbiter #(.N(NUM_REQ), .PW(PTR_W)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (win)
    );

    // Pick the winner's index, amount and digit out of the packed buses.
    // An out-of-range digit index falls back to the units digit.
    always_comb begin
        win_idx      = ptr_q;
        win_amount   = '0;
        win_digit    = '0;
        win_digit_ok = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_idx    = PTR_W'(i);
                win_amount = req_amount[i*AMOUNT_WIDTH +: AMOUNT_WIDTH];
                win_digit  = req_digit[i*DIGIT_SEL_WIDTH +: DIGIT_SEL_WIDTH];
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (win_digit == DIGIT_SEL_WIDTH'(i)) begin
                win_digit_ok = 1'b1;
            end
        end
    end

    always_comb begin
        digit_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_onehot[i] = (digit_q == DIGIT_SEL_WIDTH'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        digit_d     = digit_q;
        settle_d    = settle_q;
        grant_d     = '0;
        pulse_d     = '0;
        overflow_d  = overflow_q | top_carry;

        case (state_q)
            ST_IDLE: begin
                if (!freeze && (req != '0)) begin
                    grant_d     = win;
                    ptr_d       = win_idx;
                    remaining_d = win_amount;
                    digit_d     = win_digit_ok ? win_digit : '0;
                    // A zero-amount award is acknowledged but needs no pulses.
                    if (win_amount != '0) begin
                        state_d = ST_PULSE;
                    end
                end
            end
            ST_PULSE: begin
                // After overflow the sequence keeps its timing but the score
                // is left at its wrapped value.
                if (!overflow_q) begin
                    pulse_d = digit_onehot;
                end
                remaining_d = remaining_q - AMOUNT_WIDTH'(1);
                if (SETTLE_LEN == 0) begin
                    state_d = (remaining_q > AMOUNT_WIDTH'(1)) ? ST_PULSE : ST_IDLE;
                end else begin
                    state_d  = ST_SETTLE;
                    settle_d = CNT_W'(SETTLE_LEN - 1);
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = (remaining_q != '0) ? ST_PULSE : ST_IDLE;
                end else begin
                    settle_d = settle_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy spans the grant cycle up to and including the cycle the FSM
        // is back in IDLE: 1 + amount*NUM_DIGITS cycles per award.
        busy_d = (state_d != ST_IDLE) || (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PTR_RST;
            remaining_q <= '0;
            digit_q     <= '0;
            settle_q    <= '0;
            grant_q     <= '0;
            pulse_q     <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            digit_q     <= digit_d;
            settle_q    <= settle_d;
            grant_q     <= grant_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    assign grant       = grant_q;
    assign count_pulse = pulse_q;
    assign busy        = busy_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_score_award_sequencer.sv
// -----------------------------------------------------------------------------
// tb_score_award_sequencer
// Directed bench for score_award_sequencer with a BCD digit chain attached.
// A schedule-based model predicts grant/pulse/busy/overflow per cycle and is
// compared every cycle; directed scenarios add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_score_award_sequencer;

    localparam int NR   = 3;
    localparam int AW   = 4;
    localparam int ND   = 4;
    localparam int DW   = 2;
    localparam int MAXC = 1024;

    // clock / reset
    logic clk;
    logic resetN;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DUT signals
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_amount;
    logic [NR*DW-1:0] req_digit;
    logic             freeze;
    logic             top_carry;
    logic [NR-1:0]    grant;
    logic [ND-1:0]    count_pulse;
    logic             busy;
    logic             overflow;

    score_award_sequencer dut (
        .clk         (clk),
        .resetN      (resetN),
        .req         (req),
        .req_amount  (req_amount),
        .req_digit   (req_digit),
        .freeze      (freeze),
        .top_carry   (top_carry),
        .grant       (grant),
        .count_pulse (count_pulse),
        .busy        (busy),
        .overflow    (overflow)
    );

    // BCD digit chain: each digit increments on its pulse or the carry from
    // below; the carry out is registered.
    logic [3:0]  dig_q [4];
    logic [3:0]  carry_q;
    logic [3:0]  chain_in;
    logic        load_en;
    logic [15:0] load_val;
    logic [15:0] score;

    assign chain_in  = count_pulse | {carry_q[2:0], 1'b0};
    assign top_carry = carry_q[3];
    assign score     = {dig_q[3], dig_q[2], dig_q[1], dig_q[0]};

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 4; i++) dig_q[i] <= load_val[4*i +: 4];
            carry_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (chain_in[i]) begin
                    if (dig_q[i] == 4'd9) begin
                        dig_q[i]   <= 4'd0;
                        carry_q[i] <= 1'b1;
                    end else begin
                        dig_q[i]   <= dig_q[i] + 4'd1;
                        carry_q[i] <= 1'b0;
                    end
                end else begin
                    carry_q[i] <= 1'b0;
                end
            end
        end
    end

    // counters and logs
    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    int busy_cnt  = 0;
    int conflicts = 0;
    int g_cyc_q[$];
    logic [NR-1:0] g_vec_q[$];
    int p_cyc_q[$];
    logic [NR-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // behavioural model: each grant books its pulses and busy window into
    // per-cycle expectation arrays.
    logic [NR-1:0] exp_grant [MAXC];
    logic [ND-1:0] exp_pulse [MAXC];
    bit            exp_busy  [MAXC];
    bit            exp_ovf   [MAXC];
    int            sched_dig [MAXC];
    int m_t, m_ptr, m_free, m_win, m_j, m_n, m_d;
    bit m_ovf;

    initial begin : model
        cyc    = 0;
        m_ptr  = NR - 1;
        m_free = 0;
        m_ovf  = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            exp_grant[i] = '0; exp_pulse[i] = '0; exp_busy[i] = 1'b0;
            exp_ovf[i] = 1'b0; sched_dig[i] = -1;
        end
        forever begin
            @(posedge clk);
            m_t = cyc;
            cyc = cyc + 1;
            if (cyc < MAXC - 128) begin
                if (!resetN) begin
                    for (int i = cyc; i < MAXC; i++) begin
                        exp_grant[i] = '0; exp_pulse[i] = '0; exp_busy[i] = 1'b0;
                        sched_dig[i] = -1;
                    end
                    m_ptr  = NR - 1;
                    m_free = cyc;
                    m_ovf  = 1'b0;
                end else begin
                    if (sched_dig[cyc] >= 0 && !m_ovf) exp_pulse[cyc] = ND'(1 << sched_dig[cyc]);
                    if (top_carry) m_ovf = 1'b1;
                    if (m_t >= m_free && !freeze && req != '0) begin
                        m_win = -1;
                        for (int k = 1; k <= NR; k++) begin
                            m_j = (m_ptr + k) % NR;
                            if (m_win < 0 && ((req >> m_j) & 3'b001) != 3'b000) m_win = m_j;
                        end
                        m_n = int'((req_amount >> (AW * m_win)) & 12'hF);
                        m_d = int'((req_digit >> (DW * m_win)) & 6'h3);
                        if (m_d >= ND) m_d = 0;
                        exp_grant[cyc] = NR'(1 << m_win);
                        m_ptr = m_win;
                        for (int k = 0; k < m_n; k++) sched_dig[cyc + 1 + k*ND] = m_d;
                        if (m_n > 0) for (int k = 0; k <= m_n*ND; k++) exp_busy[cyc + k] = 1'b1;
                        m_free = cyc + m_n*ND;
                    end
                end
                exp_ovf[cyc] = m_ovf;
            end
        end
    end

    // compare process: every cycle, away from the active edge
    initial begin : compare
        forever begin
            @(negedge clk);
            if (cyc < MAXC - 128) begin
                check("grant",       int'(grant),       int'(exp_grant[cyc]));
                check("count_pulse", int'(count_pulse), int'(exp_pulse[cyc]));
                check("busy",        int'(busy),        int'(exp_busy[cyc]));
                check("overflow",    int'(overflow),    int'(exp_ovf[cyc]));
            end
            if (grant != '0) begin
                g_cyc_q.push_back(cyc);
                g_vec_q.push_back(grant);
            end
            if (count_pulse != '0) p_cyc_q.push_back(cyc);
            if (busy) busy_cnt++;
            if ((count_pulse[3:1] & carry_q[2:0]) != 3'b000) conflicts++;
        end
    end

    // driver tasks
    task automatic clear_logs();
        g_cyc_q.delete();
        g_vec_q.delete();
        p_cyc_q.delete();
        busy_cnt = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1 resetN = 1'b0;
        repeat (2) @(negedge clk);
        #1 resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_score(input logic [15:0] val);
        load_val = val;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic do_award(input int src, input int amt, input int dig,
                            output bit ok, output int gcyc);
        req_amount[src*AW +: AW] = AW'(amt);
        req_digit[src*DW +: DW]  = DW'(dig);
        req[src] = 1'b1;
        ok   = 1'b0;
        gcyc = -1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (grant[src]) begin
                ok   = 1'b1;
                gcyc = cyc;
            end
        end
        req[src] = 1'b0;
        check("award_granted", int'(ok), 1);
    endtask

    function automatic int q_at(input int idx);
        return (idx < g_cyc_q.size()) ? g_cyc_q[idx] : -1000;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "bench timeout");
    end

    int  c0, g, cf, gf;
    bit  ok;
    logic [NR-1:0] v;

    initial begin : main
        resetN = 1'b0; req = '0; req_amount = '0; req_digit = '0;
        freeze = 1'b0; load_en = 1'b0; load_val = '0;
        load_score(16'h0000);
        repeat (2) @(negedge clk);
        check("rst_grant",    int'(grant), 0);
        check("rst_pulse",    int'(count_pulse), 0);
        check("rst_busy",     int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        #1 resetN = 1'b1;
        repeat (2) @(negedge clk);

        // single award: source 1, 3 pulses on units
        clear_logs();
        c0 = cyc;
        do_award(1, 3, 0, ok, g);
        repeat (16) @(negedge clk);
        check("t1_grant_count",   g_cyc_q.size(), 1);
        check("t1_grant_latency", g - c0, 1);
        check("t1_grant_vec",     (g_vec_q.size() > 0) ? int'(g_vec_q[0]) : -1, 2);
        check("t1_pulse_count",   p_cyc_q.size(), 3);
        check("t1_first_pulse",   (p_cyc_q.size() > 0) ? p_cyc_q[0] - g : -1, 1);
        check("t1_spacing_a",     (p_cyc_q.size() > 1) ? p_cyc_q[1] - p_cyc_q[0] : -1, 4);
        check("t1_spacing_b",     (p_cyc_q.size() > 2) ? p_cyc_q[2] - p_cyc_q[1] : -1, 4);
        check("t1_busy_cycles",   busy_cnt, 13);
        check("t1_score",         int'(score), 16'h0003);

        // contention: all three requesting, amount 1 each, pointer from reset
        reset_dut();
        clear_logs();
        for (int i = 0; i < NR; i++) begin
            req_amount[i*AW +: AW] = 4'd1;
            req_digit[i*DW +: DW]  = 2'd0;
        end
        exp_q.push_back(3'b001); exp_q.push_back(3'b010);
        exp_q.push_back(3'b100); exp_q.push_back(3'b001);
        c0  = cyc;
        req = 3'b111;
        repeat (17) @(negedge clk);
        req = 3'b000;
        repeat (8) @(negedge clk);
        check("t2_grant_count", g_cyc_q.size(), 4);
        check("t2_first_latency", q_at(0) - c0, 1);
        for (int i = 0; i < 4; i++) begin
            v = (i < g_vec_q.size()) ? g_vec_q[i] : 3'b000;
            check("t2_grant_order", int'(v), int'(exp_q.pop_front()));
        end
        for (int i = 0; i < 3; i++) check("t2_grant_spacing", q_at(i + 1) - q_at(i), 5);
        check("t2_score", int'(score), 16'h0007);

        // carry spacing: 0009 + 2 on units -> 0011
        load_score(16'h0009);
        do_award(0, 2, 0, ok, g);
        repeat (12) @(negedge clk);
        check("t3_score", int'(score), 16'h0011);
        check("t3_pulse_carry_overlap", conflicts, 0);

        // overflow: 9999 + 1 wraps; later award is granted but silent
        load_score(16'h9999);
        do_award(0, 1, 0, ok, g);
        for (int k = 0; k < 30 && !overflow; k++) @(negedge clk);
        check("t4_overflow_set", int'(overflow), 1);
        check("t4_score_wrapped", int'(score), 16'h0000);
        clear_logs();
        do_award(2, 5, 1, ok, g);
        repeat (25) @(negedge clk);
        check("t4_no_pulses", p_cyc_q.size(), 0);
        check("t4_busy_cycles", busy_cnt, 21);
        check("t4_overflow_sticky", int'(overflow), 1);

        // freeze: running award completes, pending request waits
        reset_dut();
        load_score(16'h0000);
        clear_logs();
        do_award(0, 2, 0, ok, g);
        freeze = 1'b1;
        req_amount[2*AW +: AW] = 4'd1;
        req_digit[2*DW +: DW]  = 2'd2;
        req[2] = 1'b1;
        repeat (15) @(negedge clk);
        check("t5_no_grant_frozen", g_cyc_q.size(), 1);
        check("t5_award_completed", p_cyc_q.size(), 2);
        cf = cyc;
        gf = -1;
        freeze = 1'b0;
        for (int k = 0; k < 20 && gf < 0; k++) begin
            @(negedge clk);
            if (grant[2]) gf = cyc;
        end
        req[2] = 1'b0;
        check("t5_grant_after_unfreeze", gf - cf, 1);
        repeat (8) @(negedge clk);
        check("t5_score", int'(score), 16'h0102);

        // reset during SETTLE of a 10-pulse award
        clear_logs();
        do_award(1, 10, 0, ok, g);
        repeat (6) @(negedge clk);
        #1 resetN = 1'b0;
        @(negedge clk);
        check("t6_rst_grant",    int'(grant), 0);
        check("t6_rst_pulse",    int'(count_pulse), 0);
        check("t6_rst_busy",     int'(busy), 0);
        check("t6_rst_overflow", int'(overflow), 0);
        @(negedge clk);
        #1 resetN = 1'b1;
        clear_logs();
        repeat (50) @(negedge clk);
        check("t6_no_grants_after", g_cyc_q.size(), 0);
        check("t6_no_pulses_after", p_cyc_q.size(), 0);
        check("t6_idle_after",      busy_cnt, 0);

        // zero-amount award is granted without pulses or busy
        clear_logs();
        do_award(1, 0, 0, ok, g);
        repeat (6) @(negedge clk);
        check("t7_zero_granted", g_cyc_q.size(), 1);
        check("t7_zero_no_pulse", p_cyc_q.size(), 0);
        check("t7_zero_no_busy",  busy_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
